uart_ev_unpacker: RTL and testbench
===================================

Name: uart_ev_unpacker

Overview:
- Receive-side counterpart of the event line format: pops ASCII bytes from a synchronous FIFO (UART RX side) and parses each line "IIII,SSSSSSSSSSSSSSSS,EEEEEEEEEEEEEEEE,DDDDDDDDDDDDDDDD\n" back into a binary event record.
- The record is presented on a valid/ready event port.
- Malformed lines are flagged, counted and discarded up to the next '\n' (0x0A).
- Sits between the RX byte FIFO and loopback checkers or host-command logic.

Parameters:
- TS_W, 64, timestamp width in bits; must be a multiple of 4; hex digits per field = TS_W/4.
- ID_W, 16, event ID width in bits; must be a multiple of 4; hex digits = ID_W/4.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fifo_dout  in  8  FIFO head byte, first-word-fall-through; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop strobe; one byte consumed per cycle it is high.
- ev_valid  out  1  decoded record available.
- ev_ready  in  1  downstream accepts the record.
- ev_id  out  ID_W  decoded ID.
- ev_start  out  TS_W  decoded start timestamp.
- ev_end  out  TS_W  decoded end timestamp.
- ev_delta  out  TS_W  decoded delta.
- ev_delta_err  out  1  delta mismatch flag, qualified by ev_valid; tied to 0 when the optional feature is off.
- err_pulse  out  1  one-cycle pulse per malformed line.
- err_code  out  2  cause of the last error: 1 = bad hex digit, 2 = bad comma, 3 = bad terminator; holds until the next error.
- err_cnt  out  ERR_CNT_W  count of malformed lines; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0; state ID; nibble counter = ID_W/4-1; accumulators 0. Reset mid-line discards any partial record.
- Byte consumption: fifo_rd_en = ~fifo_empty && (state != OUT).
  - A byte is processed only in a cycle where fifo_rd_en=1.
  - fifo_empty gaps stall parsing with no state change.
- Hex digits:
  - Accept '0'-'9' (0x30-0x39) and 'A'-'F' (0x41-0x46); lowercase is rejected.
  - Each accepted digit shifts into the field accumulator MSB-first: acc <= {acc[W-5:0], nibble}.
- States and transitions (a "byte" below is a processed byte):
  - ID: consume ID_W/4 hex digits; the counter decrements per digit; at count 0 go to C1.
  - C1: byte must be ',' (0x2C). Go to START; load counter = TS_W/4-1.
  - START: consume TS_W/4 hex digits, then go to C2.
  - C2: ',' required, then go to END.
  - END: TS_W/4 hex digits, then go to C3.
  - C3: ',' required, then go to DELTA.
  - DELTA: TS_W/4 hex digits, then go to NL.
  - NL: byte must be '\n'. Go to OUT; ev_* registers are loaded from the accumulators in the same edge.
  - OUT: ev_valid=1; fields and ev_delta_err held stable; no pops. On ev_valid && ev_ready, clear ev_valid next cycle and go to ID with counter = ID_W/4-1.
  - RESYNC: pop and discard bytes; on '\n' go to ID.
- Latency: ev_valid rises the cycle after the '\n' pop. Minimum line period is 57 cycles (56 bytes + 1 OUT cycle with ev_ready=1).
- Error handling, for any unexpected byte in ID through NL:
  - err_pulse=1 for one cycle; err_code is set; err_cnt increments (saturating).
  - If the offending byte is '\n', go directly to ID (line terminated early).
  - Otherwise go to RESYNC.
  - Partial data never reaches ev_*.
- Exactly one err_pulse per malformed line, regardless of how many bad bytes it contains.
- Extra characters (e.g. '\r' before '\n') count as errors: code 3 at the NL position.
- The accumulator is not cleared between lines; all bits are overwritten by the full shift sequence.

Optional Feature:
- Macro: UART_EV_DELTA_CHECK_EN.
- When defined, ev_delta_err = ((ev_end - ev_start) mod 2^TS_W != ev_delta).
  - The compare is registered at the NL→OUT edge so it is valid together with ev_valid.
  - The record is still delivered, and err_cnt is not affected.
- When undefined, ev_delta_err is constant 0 and no subtractor or comparator is synthesized.

Test Plan:
- Valid line "12AB,0000000000000010,0000000000000025,0000000000000015\n", ev_ready=1 → ev_id=0x12AB, ev_start=0x10, ev_end=0x25, ev_delta=0x15; ev_valid high for 1 cycle, starting the cycle after the '\n' pop; err_cnt=0.
- Same line followed by a second line, ev_ready held low 10 cycles → fields stable, fifo_rd_en=0 throughout OUT; second record decoded correctly after release; no bytes lost.
- Line "12G4,..." then a valid line → err_pulse once at the 'G' byte, err_code=1; bytes discarded through '\n'; next record correct; err_cnt=1.
- Line "12AB;..." → err_code=2, err_cnt=1. Line "12A,\n" → single error with code 1 at ','; RESYNC consumes '\n'.
- Random fifo_empty gaps (~30% of cycles) over 100 random lines → decoded records identical to the gap-free run.
- With UART_EV_DELTA_CHECK_EN:
  - start=FFFFFFFFFFFFFFF0, end=0000000000000005, delta=0x15 → ev_delta_err=0.
  - delta=0x14 → ev_delta_err=1.
  - With the macro undefined → ev_delta_err=0 for both.

Source files
------------

// File: rtl/uart_ev_unpacker_if.sv
// rtl/uart_ev_unpacker_if.sv - RX byte FIFO, decoded event record and error status bundle
interface uart_ev_unpacker_if #(
  parameter int TS_W      = 64,
  parameter int ID_W      = 16,
  parameter int ERR_CNT_W = 16
);
  logic [7:0]           fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [ID_W-1:0]      ev_id;
  logic [TS_W-1:0]      ev_start;
  logic [TS_W-1:0]      ev_end;
  logic [TS_W-1:0]      ev_delta;
  logic                 ev_delta_err;
  logic                 err_pulse;
  logic [1:0]           err_code;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    input  fifo_dout, fifo_empty, ev_ready,
    output fifo_rd_en, ev_valid, ev_id, ev_start, ev_end, ev_delta, ev_delta_err,
           err_pulse, err_code, err_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, ev_ready,
    input  fifo_rd_en, ev_valid, ev_id, ev_start, ev_end, ev_delta, ev_delta_err,
           err_pulse, err_code, err_cnt
  );
endinterface

// File: rtl/uart_ev_unpacker.sv
// rtl/uart_ev_unpacker.sv - parses "IIII,S..S,E..E,D..D\n" lines from an RX FIFO into event records
// Define UART_EV_DELTA_CHECK_EN to flag records whose delta differs from end - start.
module uart_ev_unpacker #(
  parameter int TS_W      = 64,
  parameter int ID_W      = 16,
  parameter int ERR_CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  uart_ev_unpacker_if.master bus
);
  localparam int ID_D  = ID_W / 4;
  localparam int TS_D  = TS_W / 4;
  localparam int MAX_D = (TS_D > ID_D) ? TS_D : ID_D;
  localparam int CNT_W = $clog2(MAX_D) + 1;
  localparam logic [CNT_W-1:0] ID_LAST = CNT_W'(ID_D - 1);
  localparam logic [CNT_W-1:0] TS_LAST = CNT_W'(TS_D - 1);

  typedef enum logic [3:0] {
    S_ID, S_C1, S_START, S_C2, S_END, S_C3, S_DELTA, S_NL, S_OUT, S_RESYNC
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ID_W-1:0]      id_acc;
  logic [TS_W-1:0]      st_acc, en_acc, dl_acc;
  logic [ID_W-1:0]      ev_id_q;
  logic [TS_W-1:0]      ev_start_q, ev_end_q, ev_delta_q;
  logic                 err_pulse_q;
  logic [1:0]           err_code_q, err_code_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic       rd, hex_ok, is_lf, is_comma, shift, err, load_ev;
  logic [3:0] nib;

  assign rd       = ~bus.fifo_empty && (state != S_OUT);
  assign is_lf    = (bus.fifo_dout == 8'h0A);
  assign is_comma = (bus.fifo_dout == 8'h2C);

  // Uppercase-only hex: lowercase digits are a malformed line.
  always_comb begin
    hex_ok = 1'b0;
    nib    = 4'h0;
    if (bus.fifo_dout >= 8'h30 && bus.fifo_dout <= 8'h39) begin
      hex_ok = 1'b1;
      nib    = bus.fifo_dout[3:0];
    end else if (bus.fifo_dout >= 8'h41 && bus.fifo_dout <= 8'h46) begin
      hex_ok = 1'b1;
      nib    = bus.fifo_dout[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shift        = 1'b0;
    err          = 1'b0;
    err_code_nxt = err_code_q;
    load_ev      = 1'b0;
    unique case (state)
      S_ID, S_START, S_END, S_DELTA: begin
        if (rd) begin
          if (hex_ok) begin
            shift = 1'b1;
            if (cnt == '0) begin
              state_nxt = (state == S_ID)    ? S_C1 :
                          (state == S_START) ? S_C2 :
                          (state == S_END)   ? S_C3 : S_NL;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end else begin
            err          = 1'b1;
            err_code_nxt = 2'd1;
          end
        end
      end
      S_C1, S_C2, S_C3: begin
        if (rd) begin
          if (is_comma) begin
            state_nxt = (state == S_C1) ? S_START :
                        (state == S_C2) ? S_END : S_DELTA;
            cnt_nxt   = TS_LAST;
          end else begin
            err          = 1'b1;
            err_code_nxt = 2'd2;
          end
        end
      end
      S_NL: begin
        if (rd) begin
          if (is_lf) begin
            state_nxt = S_OUT;
            load_ev   = 1'b1;
          end else begin
            err          = 1'b1;
            err_code_nxt = 2'd3;
          end
        end
      end
      S_OUT: begin
        if (bus.ev_ready) begin
          state_nxt = S_ID;
          cnt_nxt   = ID_LAST;
        end
      end
      S_RESYNC: begin
        if (rd && is_lf) begin
          state_nxt = S_ID;
          cnt_nxt   = ID_LAST;
        end
      end
      default: begin
        state_nxt = S_ID;
        cnt_nxt   = ID_LAST;
      end
    endcase
    // A newline as the offending byte already ends the line, so skip RESYNC.
    if (err) begin
      state_nxt = is_lf ? S_ID : S_RESYNC;
      cnt_nxt   = ID_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ID;
      cnt         <= ID_LAST;
      id_acc      <= '0;
      st_acc      <= '0;
      en_acc      <= '0;
      dl_acc      <= '0;
      ev_id_q     <= '0;
      ev_start_q  <= '0;
      ev_end_q    <= '0;
      ev_delta_q  <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_cnt_q   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      err_pulse_q <= err;
      if (shift && state == S_ID)    id_acc <= {id_acc[ID_W-5:0], nib};
      if (shift && state == S_START) st_acc <= {st_acc[TS_W-5:0], nib};
      if (shift && state == S_END)   en_acc <= {en_acc[TS_W-5:0], nib};
      if (shift && state == S_DELTA) dl_acc <= {dl_acc[TS_W-5:0], nib};
      if (load_ev) begin
        ev_id_q    <= id_acc;
        ev_start_q <= st_acc;
        ev_end_q   <= en_acc;
        ev_delta_q <= dl_acc;
      end
      if (err) begin
        err_code_q <= err_code_nxt;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

`ifdef UART_EV_DELTA_CHECK_EN
  logic delta_err_q;

  always_ff @(posedge clk) begin
    if (rst)          delta_err_q <= 1'b0;
    else if (load_ev) delta_err_q <= ((en_acc - st_acc) != dl_acc);
  end

  assign bus.ev_delta_err = delta_err_q;
`else
  assign bus.ev_delta_err = 1'b0;
`endif

  assign bus.fifo_rd_en = rd;
  assign bus.ev_valid   = (state == S_OUT);
  assign bus.ev_id      = ev_id_q;
  assign bus.ev_start   = ev_start_q;
  assign bus.ev_end     = ev_end_q;
  assign bus.ev_delta   = ev_delta_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_code   = err_code_q;
  assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_uart_ev_unpacker.sv
// tb/tb_uart_ev_unpacker.sv - randomized line stream against a line-level parse model of uart_ev_unpacker
module tb_uart_ev_unpacker;
  localparam int TS_W = 64, ID_W = 16, ERR_CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_ev_unpacker_if #(.TS_W(TS_W), .ID_W(ID_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

  uart_ev_unpacker #(.TS_W(TS_W), .ID_W(ID_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [15:0] id;
    logic [63:0] st, en, dl;
    logic        derr;
  } rec_t;

  // fq entries: [7:0] byte, [8] record completes, [9] error expected, [11:10] error code
  rec_t        exp_q[$];
  logic [11:0] fq[$];
  logic [7:0]  ln[$];
  int          n_tests = 0, n_fail = 0;
  int          err_cnt_m = 0;
  logic [11:0] pend = '0;
  bit          pend_valid = 0;
  bit          use_gaps = 0;
  bit          ready_rand = 0;
  int          ready_hold = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  function automatic bit is_hexb(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F");
  endfunction

  function automatic logic [63:0] fld(input int pos, input int nd);
    logic [63:0] v = '0;
    for (int k = 0; k < nd; k++) begin
      logic [7:0] b = ln[pos+k];
      v = v * 16 + ((b <= "9") ? 64'(b - "0") : 64'(b - "A" + 10));
    end
    return v;
  endfunction

  task automatic add_field(input logic [63:0] v, input int nd);
    for (int i = nd - 1; i >= 0; i--) ln.push_back(hexc(v[i*4 +: 4]));
  endtask

  task automatic build(input logic [15:0] id, input logic [63:0] st, input logic [63:0] en,
                       input logic [63:0] dl);
    ln.delete();
    add_field(64'(id), 4);  ln.push_back(",");
    add_field(st, 16);      ln.push_back(",");
    add_field(en, 16);      ln.push_back(",");
    add_field(dl, 16);      ln.push_back(8'h0A);
  endtask

  // Scan the line against the format; the first byte out of place is the expected error.
  task automatic commit();
    int          e = -1;
    logic [1:0]  code = 2'd0;
    logic [11:0] t;
    rec_t        r;
    for (int i = 0; i <= 55 && i < ln.size(); i++) begin
      bit ok;
      bit comma_pos = (i == 4 || i == 21 || i == 38);
      if (i == 55)       ok = (ln[i] == 8'h0A);
      else if (comma_pos) ok = (ln[i] == ",");
      else               ok = is_hexb(ln[i]);
      if (!ok) begin
        e    = i;
        code = (i == 55) ? 2'd3 : comma_pos ? 2'd2 : 2'd1;
        break;
      end
    end
    if (e < 0) begin
      r.id = 16'(fld(0, 4));
      r.st = fld(5, 16);
      r.en = fld(22, 16);
      r.dl = fld(39, 16);
`ifdef UART_EV_DELTA_CHECK_EN
      r.derr = ((r.en - r.st) != r.dl);
`else
      r.derr = 1'b0;
`endif
      exp_q.push_back(r);
    end
    for (int i = 0; i < ln.size(); i++) begin
      t = {4'b0000, ln[i]};
      if (e < 0 && i == ln.size() - 1) t[8] = 1'b1;
      if (i == e) begin
        t[9]     = 1'b1;
        t[11:10] = code;
      end
      fq.push_back(t);
    end
  endtask

  task automatic push_str(input string s);
    ln.delete();
    for (int i = 0; i < s.len(); i++) ln.push_back(s[i]);
    commit();
  endtask

  task automatic step();
    logic [11:0] t;
    @(negedge clk);
    t = pend;
    check("err_pulse", 64'(bus.err_pulse), 64'(pend_valid && t[9]));
    if (pend_valid && t[9]) begin
      err_cnt_m++;
      check("err_code", 64'(bus.err_code), 64'(t[11:10]));
    end
    if (pend_valid && t[8]) check("ev_latency", 64'(bus.ev_valid), 64'd1);
    check("err_cnt", 64'(bus.err_cnt), 64'(err_cnt_m));
    bus.fifo_empty = (use_gaps && $urandom_range(0, 99) < 30) || (fq.size() == 0);
    bus.fifo_dout  = (fq.size() > 0) ? fq[0][7:0] : 8'h00;
    if (ready_hold > 0) begin
      bus.ev_ready = 1'b0;
      if (bus.ev_valid) ready_hold--;
    end else begin
      bus.ev_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    if (bus.ev_valid) begin
      check("rd_en_in_out", 64'(bus.fifo_rd_en), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ev", 64'd1, 64'd0);
      end else begin
        check("ev_id", 64'(bus.ev_id), 64'(exp_q[0].id));
        check("ev_start", bus.ev_start, exp_q[0].st);
        check("ev_end", bus.ev_end, exp_q[0].en);
        check("ev_delta", bus.ev_delta, exp_q[0].dl);
        check("ev_delta_err", 64'(bus.ev_delta_err), 64'(exp_q[0].derr));
        if (bus.ev_ready) void'(exp_q.pop_front());
      end
    end
    pend_valid = bus.fifo_rd_en;
    if (pend_valid) pend = fq.pop_front();
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() > 0 || pend_valid || bus.ev_valid) && n < 30000) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(n < 30000), 64'd1);
    check("records_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    fq.delete();
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = 8'h00;
    bus.ev_ready   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ev_valid", 64'(bus.ev_valid), 64'd0);
    check("rst_err_pulse", 64'(bus.err_pulse), 64'd0);
    check("rst_err_code", 64'(bus.err_code), 64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("rst_ev_id", 64'(bus.ev_id), 64'd0);
    check("rst_ev_delta", bus.ev_delta, 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    err_cnt_m  = 0;
    pend_valid = 0;
  endtask

  task automatic random_lines(input int n, input bit gaps);
    int kind, p;
    use_gaps   = gaps;
    ready_rand = 1;
    for (int i = 0; i < n; i++) begin
      build(16'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      kind = $urandom_range(0, 9);
      p    = $urandom_range(0, 54);
      if (kind <= 1) begin
        ln[p] = 8'($urandom_range(32, 126));
      end else if (kind == 2) begin
        while (ln.size() > p) void'(ln.pop_back());
        ln.push_back(8'h0A);
      end else if (kind == 3) begin
        ln[55] = 8'h0D;
        ln.push_back(8'h0A);
      end else if (kind == 4) begin
        ln[(p == 4 || p == 21 || p == 38) ? p + 1 : p] = 8'h61;
      end
      commit();
    end
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    build(16'h12AB, 64'h10, 64'h25, 64'h15);
    commit();
    drain();

    build(16'h12AB, 64'h10, 64'h25, 64'h15);
    commit();
    build(16'hBEEF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h1);
    commit();
    ready_hold = 10;
    drain();

    build(16'h1234, 64'h10, 64'h25, 64'h15);
    ln[2] = "G";
    commit();
    build(16'h0042, 64'h1, 64'h2, 64'h1);
    commit();
    build(16'h12AB, 64'h10, 64'h25, 64'h15);
    ln[4] = ";";
    commit();
    push_str("12A,\n");
    push_str("12\n");
    build(16'h12AB, 64'h10, 64'h25, 64'h15);
    ln[2] = 8'h61;
    commit();
    build(16'hA5A5, 64'h10, 64'h25, 64'h15);
    ln[55] = 8'h0D;
    ln.push_back(8'h0A);
    commit();
    build(16'hFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h1);
    commit();
    drain();

    build(16'h7777, 64'h10, 64'h25, 64'h15);
    commit();
    repeat (30) step();
    do_reset();
    build(16'h0001, 64'hFFFFFFFFFFFFFFF0, 64'h5, 64'h15);
    commit();
    build(16'h0002, 64'hFFFFFFFFFFFFFFF0, 64'h5, 64'h14);
    commit();
    drain();

    random_lines(30, 1'b0);
    random_lines(100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
